// File: rtl/mem_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_scheduler_if
// Description : Handshake bundle between the IF/MEM stages, the unified
//               memory and the memory-port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_scheduler_if;
    logic       if_req;
    logic       dm_req;
    logic       dm_write;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       addr_hold_en;
    logic       if_grant;
    logic       dm_grant;
    logic       stall_if;
    logic       stall_mem;
    logic       timeout_err;

    // Scheduler side
    modport slave (
        input  if_req, dm_req, dm_write, mem_ack,
        output mem_req, mem_we, addr_sel, addr_hold_en,
               if_grant, dm_grant, stall_if, stall_mem, timeout_err
    );

    // Pipeline / memory side
    modport master (
        output if_req, dm_req, dm_write, mem_ack,
        input  mem_req, mem_we, addr_sel, addr_hold_en,
               if_grant, dm_grant, stall_if, stall_mem, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_scheduler
// Description : Arbitrates a single-port unified memory between instruction
//               fetch and load/store, drives the address-mux select, stalls
//               the waiting stage and flags a hung memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_scheduler #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_port_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        FETCH = 3'd2,
        DATA  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0]       c_sel_pc   = 2'd0;
    localparam logic [1:0]       c_sel_data = 2'd1;
    localparam logic [1:0]       c_sel_hold = 2'd2;
    localparam logic [1:0]       c_sel_rst  = 2'd3;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic             r_last_data;
    logic             w_last_data_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_we_q;
    logic             r_err;

    logic             w_mem_req;
    logic             w_mem_we;
    logic [1:0]       w_addr_sel;
    logic             w_hold_en;
    logic             w_if_grant;
    logic             w_dm_grant;
    logic             w_stall_if;
    logic             w_stall_mem;
    logic             w_timeout;
    logic             w_data_entry;

    // Round-robin pick; a lone requester always wins, ties go against last_data.
    function automatic state_t f_arb(input logic ifr, input logic dmr, input logic last);
        if (dmr && (!ifr || !last))
            return DATA;
        else if (ifr)
            return FETCH;
        else
            return IDLE;
    endfunction

    assign w_timeout = (r_wait_cnt == c_cnt_last);

    // Next-state and per-state output decode.
    always_comb begin
        w_next          = r_state;
        w_last_data_nxt = r_last_data;
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_addr_sel      = c_sel_hold;
        w_hold_en       = 1'b0;
        w_if_grant      = 1'b0;
        w_dm_grant      = 1'b0;
        case (r_state)
            BOOT: begin
                w_mem_req  = 1'b1;
                w_addr_sel = c_sel_rst;
                if (bus.mem_ack) begin
                    w_if_grant = 1'b1;
                    w_next     = IDLE;
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            IDLE: begin
                w_next = f_arb(bus.if_req, bus.dm_req, r_last_data);
            end
            FETCH: begin
                w_mem_req  = 1'b1;
                w_addr_sel = c_sel_pc;
                if (bus.mem_ack) begin
                    w_if_grant      = 1'b1;
                    w_hold_en       = 1'b1;
                    w_last_data_nxt = 1'b0;
                    w_next          = f_arb(bus.if_req, bus.dm_req, 1'b0);
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            DATA: begin
                w_mem_req  = 1'b1;
                w_addr_sel = c_sel_data;
                w_mem_we   = r_we_q;
                if (bus.mem_ack) begin
                    w_dm_grant      = 1'b1;
                    w_hold_en       = 1'b1;
                    w_last_data_nxt = 1'b1;
                    w_next          = f_arb(bus.if_req, bus.dm_req, 1'b1);
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            ERR: begin
                w_next = ERR;
            end
            default: begin
                w_next = BOOT;
            end
        endcase
    end

    // Stalls hold the waiting stage; ERR freezes everything.
    always_comb begin
        w_stall_if  = 1'b1;
        w_stall_mem = 1'b1;
        if (r_state != ERR) begin
            w_stall_if  = (bus.if_req | (r_state == BOOT)) & ~w_if_grant;
            w_stall_mem = bus.dm_req & ~w_dm_grant;
        end
    end

    // A new DATA access starts on entry from another state or back-to-back after an ack.
    assign w_data_entry = (w_next == DATA) && ((r_state != DATA) || bus.mem_ack);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= BOOT;
        else
            r_state <= w_next;
    end

    // Round-robin history, wait counter, latched write enable and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_data <= 1'b0;
            r_wait_cnt  <= '0;
            r_we_q      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_last_data <= w_last_data_nxt;
            if ((w_next != r_state) || bus.mem_ack)
                r_wait_cnt <= '0;
            else if ((r_state == BOOT) || (r_state == FETCH) || (r_state == DATA))
                r_wait_cnt <= r_wait_cnt + c_cnt_one;
            if (w_data_entry)
                r_we_q <= bus.dm_write;
            if (w_next == ERR)
                r_err <= 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held, so an in-flight access drops at once.
    assign bus.mem_req      = rst_n & w_mem_req;
    assign bus.mem_we       = rst_n & w_mem_we;
    assign bus.addr_sel     = rst_n ? w_addr_sel : c_sel_rst;
    assign bus.addr_hold_en = rst_n & w_hold_en;
    assign bus.if_grant     = rst_n & w_if_grant;
    assign bus.dm_grant     = rst_n & w_dm_grant;
    assign bus.stall_if     = rst_n & w_stall_if;
    assign bus.stall_mem    = rst_n & w_stall_mem;
    assign bus.timeout_err  = rst_n & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_scheduler
// Description : Directed self-checking bench for mem_port_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_scheduler_if bus();

    mem_port_scheduler #(
        .TIMEOUT_CYCLES (15),
        .CNT_W          (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge; inputs for the new cycle go here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point for the current cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_write = 1'b0;
        bus.mem_ack  = 1'b0;

        // Reset state
        repeat (2) tick();
        mid();
        check("rst mem_req",  bus.mem_req, 0);
        check("rst mem_we",   bus.mem_we, 0);
        check("rst addr_sel", bus.addr_sel, 3);
        check("rst if_grant", bus.if_grant, 0);
        check("rst hold_en",  bus.addr_hold_en, 0);
        check("rst stall_if", bus.stall_if, 0);
        check("rst err",      bus.timeout_err, 0);

        // Boot fetch, ack in cycle 3
        tick(); rst_n = 1'b1;
        mid();
        check("boot1 mem_req",  bus.mem_req, 1);
        check("boot1 addr_sel", bus.addr_sel, 3);
        check("boot1 stall_if", bus.stall_if, 1);
        tick(); mid();
        check("boot2 mem_req",  bus.mem_req, 1);
        check("boot2 if_grant", bus.if_grant, 0);
        tick(); bus.mem_ack = 1'b1;
        mid();
        check("boot3 if_grant", bus.if_grant, 1);
        check("boot3 addr_sel", bus.addr_sel, 3);
        check("boot3 hold_en",  bus.addr_hold_en, 0);
        check("boot3 stall_if", bus.stall_if, 0);

        // IDLE with both requests pending, last_data = 0
        tick(); bus.mem_ack = 1'b0; bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_write = 1'b1;
        mid();
        check("idle mem_req",   bus.mem_req, 0);
        check("idle addr_sel",  bus.addr_sel, 2);
        check("idle stall_if",  bus.stall_if, 1);
        check("idle stall_mem", bus.stall_mem, 1);

        // DATA wins, immediate ack, then FETCH without a bubble
        tick(); bus.mem_ack = 1'b1;
        mid();
        check("d0 addr_sel",  bus.addr_sel, 1);
        check("d0 mem_we",    bus.mem_we, 1);
        check("d0 dm_grant",  bus.dm_grant, 1);
        check("d0 if_grant",  bus.if_grant, 0);
        check("d0 hold_en",   bus.addr_hold_en, 1);
        check("d0 stall_if",  bus.stall_if, 1);
        check("d0 stall_mem", bus.stall_mem, 0);
        tick(); mid();
        check("f0 addr_sel",  bus.addr_sel, 0);
        check("f0 mem_we",    bus.mem_we, 0);
        check("f0 if_grant",  bus.if_grant, 1);
        check("f0 dm_grant",  bus.dm_grant, 0);
        check("f0 stall_if",  bus.stall_if, 0);
        check("f0 stall_mem", bus.stall_mem, 1);

        // Six more back-to-back accesses: D,F,D,F,D,F
        for (int i = 0; i < 6; i++) begin
            tick(); mid();
            check($sformatf("rr%0d dm_grant", i), bus.dm_grant, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d if_grant", i), bus.if_grant, (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d stall_if", i), bus.stall_if, (i % 2 == 0) ? 1 : 0);
            if (i == 5) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
            end
        end

        // Back to IDLE; start a store
        tick(); bus.mem_ack = 1'b0; bus.dm_req = 1'b1; bus.dm_write = 1'b1;
        mid();
        check("idle2 mem_req", bus.mem_req, 0);

        // Store: dm_write toggles and dm_req drops mid-access, ack in cycle 4
        tick(); mid();
        check("st1 mem_we",    bus.mem_we, 1);
        check("st1 addr_sel",  bus.addr_sel, 1);
        check("st1 stall_mem", bus.stall_mem, 1);
        tick(); bus.dm_write = 1'b0; bus.dm_req = 1'b0;
        mid();
        check("st2 mem_we",    bus.mem_we, 1);
        check("st2 mem_req",   bus.mem_req, 1);
        check("st2 stall_mem", bus.stall_mem, 0);
        tick(); mid();
        check("st3 mem_we",    bus.mem_we, 1);
        check("st3 dm_grant",  bus.dm_grant, 0);
        tick(); bus.mem_ack = 1'b1;
        mid();
        check("st4 dm_grant",  bus.dm_grant, 1);
        check("st4 mem_we",    bus.mem_we, 1);
        check("st4 hold_en",   bus.addr_hold_en, 1);

        // IDLE with last_data = 1: FETCH wins the tie
        tick(); bus.mem_ack = 1'b0; bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_write = 1'b0;
        mid();
        check("idle3 mem_req", bus.mem_req, 0);
        tick(); mid();
        check("rr1 addr_sel", bus.addr_sel, 0);
        check("rr1 if_grant", bus.if_grant, 0);
        tick(); bus.mem_ack = 1'b1;
        mid();
        check("rr1 ack if_grant", bus.if_grant, 1);
        bus.if_req = 1'b0;

        // Load follows; reset in its second cycle
        tick(); bus.mem_ack = 1'b0;
        mid();
        check("ld1 addr_sel", bus.addr_sel, 1);
        check("ld1 mem_we",   bus.mem_we, 0);
        tick(); #1;
        check("ld2 mem_req", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("midrst mem_req",   bus.mem_req, 0);
        check("midrst addr_sel",  bus.addr_sel, 3);
        check("midrst stall_mem", bus.stall_mem, 0);
        bus.dm_req = 1'b0;
        tick(); rst_n = 1'b1;
        mid();
        check("reboot mem_req",  bus.mem_req, 1);
        check("reboot addr_sel", bus.addr_sel, 3);
        tick(); bus.mem_ack = 1'b1;
        mid();
        check("reboot if_grant", bus.if_grant, 1);

        // Timeout: load never acknowledged
        tick(); bus.mem_ack = 1'b0; bus.dm_req = 1'b1;
        mid();
        check("idle4 mem_req", bus.mem_req, 0);
        for (int k = 1; k <= 15; k++) begin
            tick(); mid();
            if (k == 1)
                check("to1 addr_sel", bus.addr_sel, 1);
            if (k == 15) begin
                check("to15 mem_req", bus.mem_req, 1);
                check("to15 err",     bus.timeout_err, 0);
            end
        end
        tick(); mid();
        check("err timeout_err", bus.timeout_err, 1);
        check("err mem_req",     bus.mem_req, 0);
        check("err stall_if",    bus.stall_if, 1);
        check("err stall_mem",   bus.stall_mem, 1);
        check("err addr_sel",    bus.addr_sel, 2);
        tick(); bus.mem_ack = 1'b1; bus.dm_req = 1'b0;
        mid();
        check("err ack dm_grant", bus.dm_grant, 0);
        check("err ack if_grant", bus.if_grant, 0);
        check("err ack stall_if", bus.stall_if, 1);
        tick(); bus.mem_ack = 1'b0;
        repeat (3) tick();
        mid();
        check("err sticky", bus.timeout_err, 1);

        // Only reset clears the error
        tick(); rst_n = 1'b0;
        #1;
        check("errrst err",      bus.timeout_err, 0);
        check("errrst stall_if", bus.stall_if, 0);
        tick(); rst_n = 1'b1;
        mid();
        check("post mem_req",  bus.mem_req, 1);
        check("post addr_sel", bus.addr_sel, 3);
        check("post err",      bus.timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
